// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// dmem_responder optionally honours DMEM_ERR_CHECK_EN.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    function automatic int idx_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: byte-lane writes, registered reads.
// Contents are intentionally not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = idx_width(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be_i[b]) begin
                        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder, one transaction in flight.
// Define DMEM_ERR_CHECK_EN to fault misaligned / out-of-range addresses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [31:0]       req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [BE_W-1:0]   req_be_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o
);

    localparam int         IDX_W    = idx_width(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              rd_sel_q, rd_sel_d;
    logic              err_q, err_d;
    logic              access;
    logic              addr_err;
    logic [DATA_W-1:0] arr_rdata;

`ifdef DMEM_ERR_CHECK_EN
    assign addr_err = (addr_q[1:0] != 2'b00) ||
                      (addr_q[31:IDX_W+2] != '0);
`else
    logic unused_addr;
    assign unused_addr = ^{addr_q[1:0], addr_q[31:IDX_W+2]};
    assign addr_err    = 1'b0;
`endif

    // Reset on the access edge must also suppress the array write.
    assign access = (state_q == ST_WAIT) && (cnt_q == 4'd0) && !rst_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rd_sel_d = rd_sel_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    be_d    = req_be_i;
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = ST_RESP;
                    err_d    = addr_err;
                    rd_sel_d = !we_q && !addr_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d  = ST_IDLE;
                    rd_sel_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            rd_sel_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_sel_q <= rd_sel_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk_i  (clk_i),
        .en_i   (access),
        .we_i   (we_q && !addr_err),
        .be_i   (be_q),
        .idx_i  (addr_q[IDX_W+1:2]),
        .wdata_i(wdata_q),
        .rdata_o(arr_rdata)
    );

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_rdata_o = rd_sel_q ? arr_rdata : '0;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a transaction-level model.
// Error-check expectations follow DMEM_ERR_CHECK_EN when defined.
module tb_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;

    int checks = 0;
    int errors = 0;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LATENCY)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o),
        .resp_err_o  (resp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem [DEPTH];

    function automatic bit model_err(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    bit          armed = 0;
    bit          busy  = 0;
    bit          vis   = 0;
    int          vis_at;
    int          k     = 0;
    bit          p_we;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [3:0]  p_be;
    logic [31:0] exp_rdata;
    bit          exp_err;

    initial begin
        forever begin
            @(negedge clk_i);
            k++;
            if (armed) begin
                if (busy && !vis && k >= vis_at) begin
                    vis = 1;
                    if (p_we && !exp_err) begin
                        for (int b = 0; b < 4; b++)
                            if (p_be[b])
                                mem[model_idx(p_addr)][8*b +: 8] = p_wdata[8*b +: 8];
                    end
                end
                chk("req_ready", 32'(req_ready_o), 32'(!busy));
                chk("resp_valid", 32'(resp_valid_o), 32'(vis));
                if (vis) begin
                    chk("resp_rdata", resp_rdata_o, exp_rdata);
                    chk("resp_err", 32'(resp_err_o), 32'(exp_err));
                end
            end
            if (rst_i) begin
                armed = 1;
                busy  = 0;
                vis   = 0;
            end else if (armed) begin
                if (!busy && req_valid_i) begin
                    busy    = 1;
                    vis     = 0;
                    vis_at  = k + 1 + LATENCY;
                    p_we    = req_we_i;
                    p_addr  = req_addr_i;
                    p_wdata = req_wdata_i;
                    p_be    = req_be_i;
                    exp_err = model_err(req_addr_i);
                    exp_rdata = (req_we_i || exp_err) ? 32'h0
                                                      : mem[model_idx(req_addr_i)];
                end else if (vis && resp_ready_i) begin
                    busy = 0;
                    vis  = 0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic junk();
        req_valid_i = 1'($urandom);
        req_we_i    = 1'($urandom);
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
        req_be_i    = 4'($urandom);
    endtask

    task automatic txn(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input int hold, output logic [31:0] rd,
                       output logic er);
        int n;
        int lat;
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_addr_i   = a;
        req_wdata_i  = wd;
        req_be_i     = be;
        resp_ready_i = 1'b0;
        n = 0;
        while (!req_ready_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!req_ready_o) chk("req_timeout", 32'(req_ready_o), 32'd1);
        @(posedge clk_i); #1;
        lat = 0;
        while (!resp_valid_o && lat < 40) begin
            junk();
            @(posedge clk_i); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(LATENCY));
        for (int i = 0; i < hold; i++) begin
            junk();
            @(posedge clk_i); #1;
        end
        resp_ready_i = 1'b1;
        rd = resp_rdata_o;
        er = resp_err_o;
        junk();
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] rd;
    logic        er;

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        req_be_i     = '0;
        resp_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("reset_ready", 32'(req_ready_o), 32'd1);
        chk("reset_valid", 32'(resp_valid_o), 32'd0);
        chk("reset_err", 32'(resp_err_o), 32'd0);
        chk("reset_rdata", resp_rdata_o, 32'd0);

        for (int i = 0; i < DEPTH; i++)
            txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, rd, er);

        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
        chk("store_rdata", rd, 32'h0);
        chk("store_err", 32'(er), 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("load_full", rd, 32'hDEADBEEF);
        txn(1'b1, 32'h10, 32'h00000011, 4'b0001, 0, rd, er);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er);
        chk("load_byte0", rd, 32'hDEADBE11);
        txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, rd, er);
        chk("be0_ack_err", 32'(er), 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);
        chk("be0_unchanged", rd, 32'hDEADBE11);

        // reset while a store sits in WAIT
        txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, rd, er);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h20;
        req_wdata_i = 32'h12345678;
        req_be_i    = 4'hF;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk("in_wait_ready", 32'(req_ready_o), 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("rst_wait_ready", 32'(req_ready_o), 32'd1);
        chk("rst_wait_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_wait_rdata", resp_rdata_o, 32'd0);
        chk("rst_wait_err", 32'(resp_err_o), 32'd0);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        chk("rst_no_commit", rd, 32'hCAFEF00D);

`ifdef DMEM_ERR_CHECK_EN
        txn(1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er);
        chk("misalign_err", 32'(er), 32'd1);
        chk("misalign_rdata", rd, 32'd0);
        txn(1'b1, 32'h0, 32'h55AA55AA, 4'hF, 0, rd, er);
        txn(1'b1, 32'h400, 32'h99999999, 4'hF, 0, rd, er);
        chk("range_err", 32'(er), 32'd1);
        txn(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er);
        chk("range_no_write", rd, 32'h55AA55AA);
`else
        txn(1'b0, 32'h413, 32'h0, 4'h0, 0, rd, er);
        chk("wrap_load", rd, 32'hDEADBE11);
        chk("wrap_err", 32'(er), 32'd0);
`endif

        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            a = $urandom;
`ifdef DMEM_ERR_CHECK_EN
            if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, DEPTH - 1) * 4);
`endif
            txn(1'($urandom), a, $urandom, 4'($urandom),
                $urandom_range(0, 3), rd, er);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            #0;
        end

        repeat (3) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the RISC-V core: the memory end of the load/store interface that the CPU datapath initiates.
- Accepts one word-sized read or write request per transaction over a valid/ready request channel.
- Models a fixed access latency and returns a response (read data or write acknowledge) on a valid/ready response channel.
- At most one transaction is outstanding. The block replaces a combinational data memory, so stalling the pipeline can be exercised.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; power of two, minimum 4.
- LATENCY, 2, cycles from request acceptance to resp_valid_o; range 1..15.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous reset, active-high
- req_valid_i  input  1  request present
- req_ready_o  output  1  responder can accept a request
- req_we_i  input  1  1 = store, 0 = load
- req_addr_i  input  32  byte address
- req_wdata_i  input  32  store data
- req_be_i  input  4  byte enables for stores; bit n covers bits [8n+7:8n]
- resp_valid_o  output  1  response present
- resp_ready_i  input  1  initiator accepts the response
- resp_rdata_o  output  32  load data; 0 for store responses
- resp_err_o  output  1  request faulted

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: state IDLE, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, latency counter 0. Memory array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o at an edge: latch we, addr, wdata and be; load the counter with LATENCY-1; go to WAIT.
- WAIT:
  - req_ready_o=0.
  - Counter decrements each cycle.
  - When the counter is 0: perform the access, register resp_rdata_o and resp_err_o, go to RESP.
- RESP:
  - resp_valid_o=1. rdata and err are held stable until resp_ready_i is sampled high.
  - On acceptance go to IDLE; resp_valid_o drops the next cycle.
- Latency: a request accepted at edge T produces resp_valid_o high from edge T+LATENCY. If resp_ready_i is held high, the next request can be accepted at edge T+LATENCY+2, giving a peak throughput of 1 per LATENCY+2 cycles.
- Word index = latched addr[log2(DEPTH_WORDS)+1:2].
- Store timing: the store commits on the WAIT-to-RESP edge.
  - Only bytes with be=1 are written.
  - be=4'b0000 still produces an acknowledge with no array change.
- Load:
  - Returns the full word; req_be_i is ignored.
  - A load accepted after a store's response returns the stored data. No hazard exists because only one transaction is outstanding.
- Store responses: resp_rdata_o=0.
- Inputs are ignored while req_ready_o=0; requests are not queued.
- Reset mid-operation: return to IDLE. Any pending response is discarded. A store still in WAIT is not committed; a store already in RESP has already committed.

Optional Feature:
- Macro: DMEM_ERR_CHECK_EN.
- Defined:
  - resp_err_o=1 if addr[1:0]!=0 or addr >= 4*DEPTH_WORDS.
  - A faulting store writes nothing.
  - A faulting load returns rdata=0.
  - Latency and handshake are unchanged.
- Undefined:
  - resp_err_o is tied to 0.
  - addr[1:0] is ignored and upper address bits wrap modulo DEPTH_WORDS.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE/WAIT/RESP),
  - the constant for data width 32 and byte-enable width 4,
  - a function computing the index width from DEPTH_WORDS.
- One sub-module, dmem_array: a single-port word array with a byte-lane write enable and registered read, instantiated once.
- FSM, counter and error check stay in dmem_responder.

Test Plan:
- Reset then idle → req_ready_o=1, resp_valid_o=0, resp_err_o=0.
- Store addr 0x10, wdata 0xDEADBEEF, be 4'hF, LATENCY=2, resp_ready_i=1 → resp_valid_o rises 2 cycles after acceptance with rdata=0, err=0. A following load of 0x10 returns 0xDEADBEEF.
- Store addr 0x10, wdata 0x00000011, be 4'b0001, then load 0x10 → 0xDEADBE11. A store with be=0 leaves the word unchanged but is still acknowledged.
- Response backpressure: hold resp_ready_i=0 for 5 cycles → resp_valid_o and rdata stay stable and req_ready_o=0 throughout. Raise resp_ready_i → IDLE the cycle after.
- Reset asserted in WAIT of a store to 0x20 (value 0x12345678) → outputs return to reset values next cycle. A later load of 0x20 returns the prior contents, not 0x12345678.
- With DMEM_ERR_CHECK_EN: load 0x13 → err=1, rdata=0. Store to 0x400 with DEPTH_WORDS=256 → err=1 and no array write. Without the macro: load 0x413 returns word index 4.
